vid_lock_ctrl: RTL and testbench
================================

VID_LOCK_CTRL -- requirements
Module: vid_lock_ctrl

Interface
REQ-001 SHALL have parameter H_WIDTH, default 1920, active pixels (de-high cycles) per line.
REQ-002 SHALL have parameter V_HEIGHT, default 1080, active lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required before the FILL state (range 1..15).
REQ-004 SHALL have port clk_i  input  1  pixel clock; the only clock; all state on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port vs_i  input  1  vertical sync; rising edge marks a frame boundary.
REQ-007 SHALL have port de_i  input  1  data enable; each high cycle is one pixel.
REQ-008 SHALL have port wen_o  output  1  write enable for the downstream frame delayer.
REQ-009 SHALL have port ren_o  output  1  read enable for the downstream frame delayer.
REQ-010 SHALL have port locked_o  output  1  high in the RUN state.
REQ-011 SHALL have port state_o  output  2  current state: SEARCH=0, CHECK=1, FILL=2, RUN=3.
REQ-012 SHALL have port err_o  output  1  one-cycle pulse when a bad frame is detected in FILL or RUN.
REQ-013 SHALL have port frame_cnt_o  output  16  count of good frames completed in RUN; wraps modulo 2^16.

Function
REQ-014 SHALL register vs_i and de_i once (vs_r, de_r); vs_rise = vs_i & ~vs_r and de_fall = ~de_i & de_r, both combinational.
REQ-015 SHALL keep a 12-bit pixel counter: +1 per de_i high cycle, saturating at 4095, cleared on the cycle after each de_fall.
REQ-016 SHALL, on de_fall, set a sticky line_bad flag if the pixel count != H_WIDTH, and increment an 11-bit line counter that saturates at 2047.
REQ-017 SHALL treat a frame as good at vs_rise iff line count == V_HEIGHT and line_bad == 0, evaluated over everything since the previous vs_rise.
REQ-018 SHALL, when de_fall and vs_rise occur in the same cycle, count that line end (and its pixel check) toward the frame ending at that vs_rise.
REQ-019 SHALL clear the line counter, line_bad, and pixel counter on every vs_rise (next cycle values 0); a de_i high on the vs_rise cycle SHALL count as pixel 1 of the new frame.
REQ-020 SHALL implement the FSM: SEARCH -> CHECK on the first vs_rise (partial frame discarded, good-frame counter = 0).
REQ-021 SHALL in CHECK, on vs_rise: good frame -> increment the 4-bit good-frame counter; on reaching LOCK_FRAMES -> FILL; bad frame -> counter = 0, stay in CHECK, no err_o.
REQ-022 SHALL in FILL, on vs_rise: good frame -> RUN; bad frame -> CHECK, counter = 0, err_o pulse.
REQ-023 SHALL in RUN, on vs_rise: good frame -> stay, frame_cnt_o + 1; bad frame -> CHECK, counter = 0, err_o pulse, frame_cnt_o unchanged.
REQ-024 SHALL register the outputs from the state: wen_o = (FILL or RUN), ren_o = RUN, locked_o = RUN; all change on the clock edge after the vs_rise cycle, together with state_o.
REQ-025 SHALL assert err_o for exactly the single cycle after the offending vs_rise.
REQ-026 SHALL ignore de_i activity while vs_i is held high; only edges are significant.

Reset
REQ-027 SHALL, on rst_i high, immediately set: state SEARCH, wen_o = ren_o = locked_o = err_o = 0, frame_cnt_o = 0, all counters and flags 0, vs_r = de_r = 0.
REQ-028 SHALL, when reset is released mid-frame, detect no vs_rise until vs_i is low for at least one cycle then high.

Verification
REQ-029 SHALL cover clean lock: H_WIDTH=8, V_HEIGHT=4, LOCK_FRAMES=2, with 5 good frames -> state 0->1 at vs#1, ->2 at vs#3 (wen_o=1), ->3 at vs#4 (ren_o=1), frame_cnt_o=1 after vs#5.
REQ-030 SHALL cover a short line: in RUN, one line with 7 pixels -> at the next vs_rise: err_o one pulse, state=1, wen_o=ren_o=0, frame_cnt_o held.
REQ-031 SHALL cover a wrong line count: a 5-line frame in CHECK with counter=1 -> counter 0, no err_o, 2 further good frames are needed to reach FILL.
REQ-032 SHALL cover coincidence: the last de_fall on the same cycle as vs_rise with an 8-pixel line -> frame judged good.
REQ-033 SHALL cover async reset in RUN mid-line: all outputs 0 without a clock edge; after release, state 0 until the next vs_rise.
REQ-034 SHALL cover wrap: frame_cnt_o preloaded or driven to 65535 in RUN, then one good frame -> 0.

Source files
------------

// File: rtl/vid_lock_ctrl.sv
// Video timing lock controller: qualifies frames by line/pixel geometry and walks
// SEARCH -> CHECK -> FILL -> RUN to gate a downstream frame delayer.
module vid_lock_ctrl #(
    parameter int unsigned H_WIDTH     = 1920,
    parameter int unsigned V_HEIGHT    = 1080,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vs_i,
    input  logic        de_i,
    output logic        wen_o,
    output logic        ren_o,
    output logic        locked_o,
    output logic [1:0]  state_o,
    output logic        err_o,
    output logic [15:0] frame_cnt_o
);

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StCheck  = 2'd1,
        StFill   = 2'd2,
        StRun    = 2'd3
    } state_e;

    localparam logic [11:0] PixTarget  = 12'(H_WIDTH);
    localparam logic [10:0] LineTarget = 11'(V_HEIGHT);
    localparam logic [3:0]  LockTarget = 4'(LOCK_FRAMES);

    state_e      state_q, state_d;
    logic        vs_q, de_q, armed_q;
    logic [11:0] pix_q, pix_d;
    logic [10:0] line_q, line_d;
    logic        line_bad_q, line_bad_d;
    logic [3:0]  good_q, good_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_q, err_d;
    logic        wen_q, ren_q, locked_q;

    logic        vs_hold, vs_rise, de_act, de_fall;
    logic [11:0] pix_inc;
    logic [10:0] line_inc, frame_lines;
    logic        frame_bad, frame_good;

    // armed_q blocks a false edge when reset releases with vs_i already high
    always_comb begin
        vs_hold     = vs_i & vs_q;
        vs_rise     = vs_i & ~vs_q & armed_q;
        de_act      = de_i & ~vs_hold;
        de_fall     = ~de_i & de_q & ~vs_hold;
        pix_inc     = (pix_q == 12'hfff) ? pix_q : pix_q + 12'd1;
        line_inc    = (line_q == 11'h7ff) ? line_q : line_q + 11'd1;
        frame_lines = de_fall ? line_inc : line_q;
        frame_bad   = line_bad_q | (de_fall & (pix_q != PixTarget));
        frame_good  = (frame_lines == LineTarget) & ~frame_bad;
    end

    always_comb begin
        pix_d      = pix_q;
        line_d     = line_q;
        line_bad_d = line_bad_q;
        if (vs_rise) begin
            pix_d      = de_act ? 12'd1 : 12'd0;
            line_d     = '0;
            line_bad_d = 1'b0;
        end else if (de_fall) begin
            pix_d      = '0;
            line_d     = line_inc;
            line_bad_d = frame_bad;
        end else if (de_act) begin
            pix_d = pix_inc;
        end
    end

    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = 1'b0;
        if (vs_rise) begin
            unique case (state_q)
                StSearch: begin
                    state_d = StCheck;
                    good_d  = '0;
                end
                StCheck: begin
                    if (frame_good) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LockTarget) state_d = StFill;
                    end else begin
                        good_d = '0;
                    end
                end
                StFill: begin
                    if (frame_good) begin
                        state_d = StRun;
                    end else begin
                        state_d = StCheck;
                        good_d  = '0;
                        err_d   = 1'b1;
                    end
                end
                StRun: begin
                    if (frame_good) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        state_d = StCheck;
                        good_d  = '0;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StSearch;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            armed_q     <= 1'b0;
            pix_q       <= '0;
            line_q      <= '0;
            line_bad_q  <= 1'b0;
            good_q      <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= vs_i;
            de_q        <= de_i;
            armed_q     <= armed_q | ~vs_i;
            pix_q       <= pix_d;
            line_q      <= line_d;
            line_bad_q  <= line_bad_d;
            good_q      <= good_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            wen_q       <= (state_d == StFill) || (state_d == StRun);
            ren_q       <= (state_d == StRun);
            locked_q    <= (state_d == StRun);
        end
    end

    assign state_o     = state_q;
    assign wen_o       = wen_q;
    assign ren_o       = ren_q;
    assign locked_o    = locked_q;
    assign err_o       = err_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_vid_lock_ctrl.sv
// Scoreboard bench for vid_lock_ctrl: frames are built from line-length lists and
// judged by a frame-level reference model; a monitor checks outputs after each vs rise.
module tb_vid_lock_ctrl;

    localparam int H = 8;
    localparam int V = 4;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        vs_i = 1'b0;
    logic        de_i = 1'b0;
    logic        wen_o, ren_o, locked_o, err_o;
    logic [1:0]  state_o;
    logic [15:0] frame_cnt_o;

    vid_lock_ctrl #(
        .H_WIDTH    (H),
        .V_HEIGHT   (V),
        .LOCK_FRAMES(L)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .vs_i       (vs_i),
        .de_i       (de_i),
        .wen_o      (wen_o),
        .ren_o      (ren_o),
        .locked_o   (locked_o),
        .state_o    (state_o),
        .err_o      (err_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int wen;
        int ren;
        int lck;
        int err;
        int fc;
    } exp_t;

    exp_t exp_q[$];
    int   lines_q[$];
    int   m_st = 0;
    int   m_good = 0;
    int   m_fc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a frame is good iff it had exactly V lines, all of H pixels.
    function automatic void model_frame();
        exp_t e;
        bit   good;
        good = (lines_q.size() == V);
        foreach (lines_q[i]) if (lines_q[i] != H) good = 0;
        lines_q.delete();
        e.err = 0;
        case (m_st)
            0: begin m_st = 1; m_good = 0; end
            1: begin
                if (good) begin
                    m_good++;
                    if (m_good == L) m_st = 2;
                end else begin
                    m_good = 0;
                end
            end
            2: begin
                if (good) m_st = 3;
                else begin m_st = 1; m_good = 0; e.err = 1; end
            end
            default: begin
                if (good) m_fc = (m_fc + 1) % 65536;
                else begin m_st = 1; m_good = 0; e.err = 1; end
            end
        endcase
        e.st  = m_st;
        e.wen = (m_st >= 2) ? 1 : 0;
        e.ren = (m_st == 3) ? 1 : 0;
        e.lck = (m_st == 3) ? 1 : 0;
        e.fc  = m_fc;
        exp_q.push_back(e);
    endfunction

    task automatic tick(input logic v, input logic d);
        vs_i = v;
        de_i = d;
        @(negedge clk);
    endtask

    task automatic line(input int len, input int gap);
        repeat (len) tick(1'b0, 1'b1);
        repeat (gap) tick(1'b0, 1'b0);
        lines_q.push_back(len);
    endtask

    task automatic vs_edge();
        model_frame();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        repeat ($urandom_range(1, 3)) tick(1'b0, 1'b0);
    endtask

    // coinc: last line's de fall lands on the vs rise cycle
    task automatic send_frame(input int nl, input int badline, input int badlen, input bit coinc);
        for (int i = 0; i < nl; i++) begin
            int len;
            int gap;
            len = (i == badline) ? badlen : H;
            gap = (coinc && i == nl - 1) ? 0 : int'($urandom_range(1, 3));
            line(len, gap);
        end
        vs_edge();
    endtask

    // Monitor: after every vs rise seen outside reset, pop and compare, then check err drops.
    initial begin
        logic mon_prev;
        logic rise;
        exp_t e;
        mon_prev = 1'b0;
        forever begin
            @(posedge clk);
            rise     = !rst_i && vs_i && !mon_prev;
            mon_prev = vs_i;
            if (rise) begin
                #1;
                if (exp_q.size() == 0) begin
                    check("unexpected_vs_rise", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("state", int'(state_o), e.st);
                    check("wen", int'(wen_o), e.wen);
                    check("ren", int'(ren_o), e.ren);
                    check("locked", int'(locked_o), e.lck);
                    check("err_pulse", int'(err_o), e.err);
                    check("frame_cnt", int'(frame_cnt_o), e.fc);
                end
                @(posedge clk);
                #1;
                check("err_single_cycle", int'(err_o), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_i = 1'b1;
        #1;
        check("rst_state", int'(state_o), 0);
        check("rst_wen", int'(wen_o), 0);
        check("rst_ren", int'(ren_o), 0);
        check("rst_locked", int'(locked_o), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_frame_cnt", int'(frame_cnt_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        tick(1'b0, 1'b0);

        // Partial frame, then lock sequence
        line(H, 2);
        line(5, 2);
        vs_edge();
        check("lock_vs1_state", int'(state_o), 1);
        send_frame(V, -1, 0, 0);
        send_frame(V, -1, 0, 0);
        check("lock_vs3_state", int'(state_o), 2);
        check("lock_vs3_wen", int'(wen_o), 1);
        check("lock_vs3_ren", int'(ren_o), 0);
        send_frame(V, -1, 0, 0);
        check("lock_vs4_state", int'(state_o), 3);
        check("lock_vs4_ren", int'(ren_o), 1);
        send_frame(V, -1, 0, 0);
        check("lock_vs5_frame_cnt", int'(frame_cnt_o), 1);

        // Short line in RUN
        send_frame(V, 2, H - 1, 0);
        check("short_state", int'(state_o), 1);
        check("short_wen", int'(wen_o), 0);
        check("short_frame_cnt", int'(frame_cnt_o), 1);

        // Wrong line count in CHECK with one good frame banked
        send_frame(V, -1, 0, 0);
        send_frame(V + 1, -1, 0, 0);
        send_frame(V, -1, 0, 0);
        check("relock_still_check", int'(state_o), 1);
        send_frame(V, -1, 0, 0);
        check("relock_fill", int'(state_o), 2);
        send_frame(V, -1, 0, 0);

        // Coincident de fall and vs rise
        send_frame(V, -1, 0, 1);
        check("coinc_frame_cnt", int'(frame_cnt_o), 2);

        // Wrap of the RUN frame counter
        force dut.frame_cnt_q = 16'hffff;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        release dut.frame_cnt_q;
        m_fc = 65535;
        check("preload_frame_cnt", int'(frame_cnt_o), 65535);
        send_frame(V, -1, 0, 0);
        check("wrap_frame_cnt", int'(frame_cnt_o), 0);

        // Randomized frames
        repeat (40) begin
            int r;
            int bl;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                send_frame(V, -1, 0, 1'($urandom_range(0, 1)));
            end else if (r < 8) begin
                bl = int'($urandom_range(1, 12));
                if (bl == H) bl = H + 1;
                send_frame(V, int'($urandom_range(0, V - 1)), bl, 1'($urandom_range(0, 1)));
            end else if (r == 8) begin
                send_frame(V - 1, -1, 0, 1'($urandom_range(0, 1)));
            end else begin
                send_frame(V + 1, -1, 0, 1'($urandom_range(0, 1)));
            end
        end

        // Reach RUN, then reset mid-line
        repeat (4) send_frame(V, -1, 0, 0);
        repeat (3) tick(1'b0, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_state", int'(state_o), 0);
        check("arst_wen", int'(wen_o), 0);
        check("arst_ren", int'(ren_o), 0);
        check("arst_locked", int'(locked_o), 0);
        check("arst_err", int'(err_o), 0);
        check("arst_frame_cnt", int'(frame_cnt_o), 0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        rst_i = 1'b0;
        m_st = 0;
        m_good = 0;
        m_fc = 0;
        lines_q.delete();
        repeat (3) tick(1'b1, 1'b0);
        check("post_rst_vs_high_state", int'(state_o), 0);
        tick(1'b0, 1'b0);
        line(H, 2);
        check("post_rst_pre_edge_state", int'(state_o), 0);
        vs_edge();
        check("post_rst_edge_state", int'(state_o), 1);
        send_frame(V, -1, 0, 0);
        send_frame(V, -1, 0, 0);

        repeat (4) tick(1'b0, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
